// File: rtl/pattern_checker_pkg.sv
// Shared types and helpers for the pattern applier / response checker.
package pattern_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    SAMPLE,
    DONE
  } pc_state_e;

  // Index width for a memory of n entries; never narrower than one bit.
  function automatic int pc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_mem.sv
// Pattern register file: synchronous write, asynchronous read.
module pattern_mem
  import pattern_checker_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int IW   = pc_idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_checker.sv
// Applies stored patterns to a circuit under test, waits SETTLE cycles,
// then samples and compares the masked response, streaming one record per pattern.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int NUM_PI = 4,
  parameter int NUM_PO = 2,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1,
  localparam int IW    = pc_idx_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [NUM_PI-1:0] load_pi,
  input  logic [NUM_PO-1:0] load_exp,
  input  logic [NUM_PO-1:0] load_mask,
  input  logic              clear,
  input  logic              start,
  output logic [NUM_PI-1:0] dut_pi,
  input  logic [NUM_PO-1:0] dut_po,
  output logic              resp_valid,
  output logic [IW-1:0]     resp_idx,
  output logic [NUM_PO-1:0] resp_po,
  output logic              resp_fail,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     pat_count,
  output logic [CW-1:0]     fail_count,
  output logic              first_fail_valid,
  output logic [IW-1:0]     first_fail_idx
);

  typedef struct packed {
    logic [NUM_PI-1:0] pi;
    logic [NUM_PO-1:0] exp;
    logic [NUM_PO-1:0] mask;
  } entry_t;

  localparam int            SW          = pc_idx_w(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

  pc_state_e     state_q, state_d;
  logic [IW-1:0] idx;
  logic [SW-1:0] settle_cnt;
  entry_t        wentry, rentry;
  logic          load_fire, run_init, last_idx, fail, idle_or_done;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign load_ready   = (state_q == IDLE) && (pat_count < DEPTH_C);
  assign load_fire    = load_valid && load_ready && !clear;
  assign run_init     = start && !clear && idle_or_done;
  assign busy         = !idle_or_done;
  assign done         = (state_q == DONE);
  assign last_idx     = (CW'(idx) == (pat_count - CW'(1)));
  assign fail         = |((dut_po ^ rentry.exp) & rentry.mask);

  assign wentry.pi   = load_pi;
  assign wentry.exp  = load_exp;
  assign wentry.mask = load_mask;

  pattern_mem #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (load_fire),
    .waddr (pat_count[IW-1:0]),
    .wdata (wentry),
    .raddr (idx),
    .rdata (rentry)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear)      state_d = IDLE;
        else if (start) state_d = (pat_count == '0) ? DONE : APPLY;
      end
      APPLY:  state_d = WAIT;
      WAIT:   if (settle_cnt == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE: state_d = last_idx ? DONE : APPLY;
      DONE: begin
        if (clear)      state_d = IDLE;
        else if (start) state_d = APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drive, settle count, response record and run statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= '0;
      settle_cnt       <= '0;
      pat_count        <= '0;
      dut_pi           <= '0;
      resp_valid       <= 1'b0;
      resp_idx         <= '0;
      resp_po          <= '0;
      resp_fail        <= 1'b0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (load_fire) pat_count <= pat_count + CW'(1);
      if (clear && idle_or_done) pat_count <= '0;
      if (run_init) begin
        idx              <= '0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
      end
      case (state_q)
        APPLY: begin
          dut_pi     <= rentry.pi;
          settle_cnt <= '0;
        end
        WAIT: settle_cnt <= settle_cnt + SW'(1);
        SAMPLE: begin
          resp_valid <= 1'b1;
          resp_idx   <= idx;
          resp_po    <= dut_po;
          resp_fail  <= fail;
          if (fail) begin
            fail_count <= fail_count + CW'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= idx;
            end
          end
          if (!last_idx) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
